// File: rtl/port_prio_scheduler_pkg.sv
// Shared constants, FSM encoding and weight helper
// for the per-port priority scheduler.
package port_prio_scheduler_pkg;

    localparam int NUM_PRIO = 8;
    localparam int PRIO_W   = 3;
    localparam int WEIGHT_W = 4;
    localparam int LEN_W    = 7;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT_ACK,
        S_XFER
    } state_t;

    // A zero weight still grants one packet per round.
    function automatic logic [WEIGHT_W-1:0] fix_weight(
        input logic [WEIGHT_W-1:0] w
    );
        return (w == '0) ? WEIGHT_W'(1) : w;
    endfunction

endpackage

// File: rtl/wrr_credit_sel.sv
// Combinational queue selector: strict priority or
// wrapped credit scan with round reload decision.
module wrr_credit_sel
    import port_prio_scheduler_pkg::*;
(
    input  logic                         wrr_mode,
    input  logic                         force_reload,
    input  logic [PRIO_W-1:0]            ptr,
    input  logic [NUM_PRIO-1:0]          eligible,
    input  logic [NUM_PRIO*WEIGHT_W-1:0] credit,
    output logic                         sel_valid,
    output logic [PRIO_W-1:0]            sel_prio,
    output logic                         reload
);

    logic [NUM_PRIO-1:0] has_credit;
    logic [NUM_PRIO-1:0] cand;
    logic [PRIO_W-1:0]   idx;

    always_comb begin
        has_credit = '0;
        for (int i = 0; i < NUM_PRIO; i++) begin
            has_credit[i] = eligible[i] &&
                (credit[i*WEIGHT_W +: WEIGHT_W] != '0);
        end
        reload = force_reload ||
            (wrr_mode && (|eligible) && !(|has_credit));
        // After a reload every credit is at least one.
        cand      = reload ? eligible : has_credit;
        sel_valid = |eligible;
        sel_prio  = '0;
        idx       = '0;
        if (!wrr_mode) begin
            for (int i = NUM_PRIO - 1; i >= 0; i--) begin
                if (eligible[i]) sel_prio = PRIO_W'(i);
            end
        end else begin
            for (int k = NUM_PRIO - 1; k >= 0; k--) begin
                idx = ptr + PRIO_W'(k);
                if (cand[idx]) sel_prio = idx;
            end
        end
    end

endmodule

// File: rtl/port_prio_scheduler.sv
// Egress port scheduler: grants a queue, requests its
// head packet and sequences the beats.
module port_prio_scheduler
    import port_prio_scheduler_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         sp0_wrr1,
    input  logic [NUM_PRIO*WEIGHT_W-1:0] wrr_weight,
    input  logic [NUM_PRIO-1:0]          prepared,
    input  logic [NUM_PRIO-1:0]          ready,
    input  logic                         out_ready,
    input  logic                         rd_ack,
    input  logic [LEN_W-1:0]             pkt_len,
    output logic                         rd_req,
    output logic [PRIO_W-1:0]            rd_prio,
    output logic                         next_data,
    output logic                         rd_sop,
    output logic                         rd_eop,
    output logic                         rd_vld,
    output logic                         len_err
);

    state_t state, state_nxt;

    logic [NUM_PRIO-1:0]          eligible;
    logic [NUM_PRIO*WEIGHT_W-1:0] credit;
    logic [PRIO_W-1:0]            rr_ptr;
    logic [PRIO_W-1:0]            scan_ptr;
    logic [PRIO_W-1:0]            sel_prio;
    logic                         sel_valid;
    logic                         reload;
    logic                         mode_q;
    logic                         mode_chg;
    logic                         started;
    logic                         beat;
    logic [LEN_W-1:0]             remaining;
    logic [WEIGHT_W-1:0]          cur_credit;
    logic [WEIGHT_W-1:0]          left;

    assign eligible = prepared & ready;
    assign mode_chg = sp0_wrr1 != mode_q;
    assign scan_ptr = mode_chg ? '0 : rr_ptr;
    assign beat     = (state == S_XFER) && out_ready;

    wrr_credit_sel u_sel (
        .wrr_mode     (sp0_wrr1),
        .force_reload (mode_chg),
        .ptr          (scan_ptr),
        .eligible     (eligible),
        .credit       (credit),
        .sel_valid    (sel_valid),
        .sel_prio     (sel_prio),
        .reload       (reload)
    );

    always_comb begin
        cur_credit = reload
            ? fix_weight(wrr_weight[sel_prio*WEIGHT_W +: WEIGHT_W])
            : credit[sel_prio*WEIGHT_W +: WEIGHT_W];
        left = cur_credit - WEIGHT_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:     if (sel_valid) state_nxt = S_REQ;
            S_REQ:      state_nxt = S_WAIT_ACK;
            S_WAIT_ACK: if (rd_ack) begin
                state_nxt = (pkt_len == '0) ? S_IDLE : S_XFER;
            end
            S_XFER:     if (beat && remaining == LEN_W'(1)) begin
                state_nxt = S_IDLE;
            end
            default:    state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        rd_req    = state == S_REQ;
        rd_vld    = state == S_XFER;
        rd_sop    = (state == S_XFER) && !started;
        rd_eop    = (state == S_XFER) && remaining == LEN_W'(1);
        next_data = beat;
        len_err   = (state == S_WAIT_ACK) && rd_ack &&
                    pkt_len == '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_prio   <= '0;
            credit    <= '0;
            rr_ptr    <= '0;
            mode_q    <= 1'b0;
            remaining <= '0;
            started   <= 1'b0;
        end else begin
            if (state == S_IDLE) begin
                mode_q <= sp0_wrr1;
                if (reload) begin
                    for (int i = 0; i < NUM_PRIO; i++) begin
                        credit[i*WEIGHT_W +: WEIGHT_W] <=
                            fix_weight(wrr_weight[i*WEIGHT_W +: WEIGHT_W]);
                    end
                end
                if (mode_chg) rr_ptr <= '0;
                if (sel_valid) begin
                    rd_prio <= sel_prio;
                    if (sp0_wrr1) begin
                        credit[sel_prio*WEIGHT_W +: WEIGHT_W] <= left;
                        rr_ptr <= (left == '0)
                            ? sel_prio + PRIO_W'(1) : sel_prio;
                    end
                end
            end
            if (state == S_WAIT_ACK && rd_ack) begin
                remaining <= pkt_len;
                started   <= 1'b0;
            end
            if (beat) begin
                remaining <= remaining - LEN_W'(1);
                started   <= 1'b1;
            end
        end
    end

endmodule
